// File: rtl/dmem_if.sv
// Load/store request and response bundle between the memory stage and the data memory.
// The master issues requests; the slave (the memory model) answers them.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory model with programmable wait states, byte-lane
// stores, and alignment/range/empty-enable fault detection.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 0..15");
   end
   if (DEPTH_WORDS < 2) begin : g_bad_depth
      $error("dmem_responder: DEPTH_WORDS must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              ready_q;
   logic              resp_valid_q;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   logic              lat_we;
   logic              lat_err;
   logic [IDX_W-1:0]  lat_idx;
   logic [31:0]       lat_wdata;
   logic [3:0]        lat_be;

   logic [31:0]       mem [DEPTH_WORDS];

   // Fault and index decode of the request currently on the bus.
   logic              in_range;
   logic              in_err;
   logic [IDX_W-1:0]  in_idx;

   assign in_range = ({2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS));
   assign in_err   = (bus.req_addr[1:0] != 2'b00) || !in_range ||
                     (bus.req_we && (bus.req_be == 4'b0000));
   assign in_idx   = bus.req_addr[IDX_W+1:2];

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

   // Response outputs are registered, so the read data is fetched on the edge
   // that enters RESP; with LATENCY=0 that edge is the handshake itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_we    <= bus.req_we;
                  lat_err   <= in_err;
                  lat_idx   <= in_idx;
                  lat_wdata <= bus.req_wdata;
                  lat_be    <= bus.req_be;
                  cnt       <= 4'(LATENCY);
                  ready_q   <= 1'b0;
                  if (LATENCY == 0) begin
                     state        <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= in_err;
                     resp_rdata_q <= (in_err || bus.req_we) ? 32'd0 : mem[in_idx];
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state        <= RESP;
                  cnt          <= 4'd0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= lat_err;
                  resp_rdata_q <= (lat_err || lat_we) ? 32'd0 : mem[lat_idx];
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: the backing array has no reset; only the control path does, and a
   // reset during RESP must still suppress the pending store.
   always_ff @(posedge clk) begin
      if (!rst && state == RESP && lat_we && !lat_err) begin
         for (int n = 0; n < 4; n++) begin
            if (lat_be[n]) mem[lat_idx][8*n +: 8] <= lat_wdata[8*n +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, pipelined-hold, reset-abort,
// zero-latency build, and random traffic against a word-array reference model.
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_if b2 ();
   dmem_if b0 ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0))   u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: words written so far, keyed by word index.
   logic [31:0] model_mem [int];

   function automatic logic ref_err(input logic we, input logic [31:0] addr, input logic [3:0] be);
      return (addr % 4 != 0) || ((addr / 4) >= DEPTH) || (we && be == 4'd0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr);
      int idx = int'(addr / 4);
      return model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
      int idx = int'(addr / 4);
      logic [31:0] w = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
      for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = wdata[8*n +: 8];
      model_mem[idx] = w;
   endtask

   // One transaction on the LATENCY=2 instance, with handshake/response timing checks.
   task automatic run_op(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic exp_err, input logic [31:0] exp_rdata);
      int guard;
      int lat;
      @(negedge clk);
      b2.req_valid = 1'b1; b2.req_we = we; b2.req_addr = addr;
      b2.req_wdata = wdata; b2.req_be = be;
      guard = 0;
      while (!b2.req_ready && guard < 20) begin @(negedge clk); guard++; end
      check({name, "_accept"}, 32'(b2.req_ready), 32'd1);
      @(negedge clk);
      // Scramble the bus after the handshake; the responder must use its latched copy.
      b2.req_valid = 1'b0; b2.req_we = ~we; b2.req_addr = $urandom;
      b2.req_wdata = $urandom; b2.req_be = 4'($urandom);
      lat = 1;
      while (!b2.resp_valid && lat < 40) begin @(negedge clk); lat++; end
      check({name, "_latency"}, 32'(lat), 32'(LAT + 1));
      check({name, "_err"}, 32'(b2.resp_err), 32'(exp_err));
      if (!$isunknown(exp_rdata)) check({name, "_rdata"}, b2.resp_rdata, exp_rdata);
      check({name, "_busy"}, 32'(b2.req_ready), 32'd0);
      @(negedge clk);
      check({name, "_pulse"}, {b2.resp_valid, b2.resp_err, b2.req_ready, 29'd0},
            {1'b0, 1'b0, 1'b1, 29'd0});
      check({name, "_rdata_idle"}, b2.resp_rdata, 32'd0);
      if (we && !exp_err) ref_store(addr, wdata, be);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   int          hs[$];
   int          rv[$];
   logic [31:0] rd[$];
   logic [31:0] hold_addr [3];
   int          n_hs;
   int          ready_low;
   int          resp_seen;
   logic [31:0] ra, rw;
   logic [3:0]  rb;
   logic        rwe;
   int          sel;

   initial begin
      vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
      vecs.push_back('{1'b1, 32'h20,   32'h11223344, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 1'b0, 32'h0});
      // Lanes 0 and 2 take the new bytes, lanes 1 and 3 keep the old ones.
      vecs.push_back('{1'b0, 32'h20,   32'h0,        4'h0, 1'b0, 32'h11BB33DD});
      vecs.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 32'h0,    32'h0BADF00D, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'(DEPTH*4), 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0BADF00D});
      vecs.push_back('{1'b1, 32'h24,   32'h55667788, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h24,   32'hFFFFFFFF, 4'h0, 1'b1, 32'h0});
      vecs.push_back('{1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h55667788});
      vecs.push_back('{1'b1, 32'h40,   32'h00000000, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'(DEPTH*4-4), 32'hCAFEF00D, 4'hF, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'(DEPTH*4-4), 32'h0,  4'h0, 1'b0, 32'hCAFEF00D});

      b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0; b2.req_be = '0;
      b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.req_be = '0;

      // Reset state of both builds.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready2", 32'(b2.req_ready), 32'd1);
      check("rst_resp2",  {b2.resp_valid, b2.resp_err, 30'd0}, 32'd0);
      check("rst_rdata2", b2.resp_rdata, 32'd0);
      check("rst_ready0", 32'(b0.req_ready), 32'd1);
      check("rst_resp0",  {b0.resp_valid, b0.resp_err, 30'd0}, 32'd0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_err, vecs[i].exp_rdata);

      // Three back-to-back loads with req_valid held high.
      hold_addr[0] = 32'h10; hold_addr[1] = 32'h20; hold_addr[2] = 32'h0;
      n_hs = 0; ready_low = 0;
      @(negedge clk);
      b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = hold_addr[0]; b2.req_be = 4'h0;
      for (int k = 0; k < 14; k++) begin
         if (b2.resp_valid) begin rv.push_back(k); rd.push_back(b2.resp_rdata); end
         if (k < 12 && !b2.req_ready) ready_low++;
         if (b2.req_valid && b2.req_ready) begin hs.push_back(k); n_hs++; end
         @(negedge clk);
         if (n_hs >= 3) b2.req_valid = 1'b0;
         else b2.req_addr = hold_addr[n_hs];
      end
      check("hold_hs_count",   32'(hs.size()), 32'd3);
      check("hold_resp_count", 32'(rv.size()), 32'd3);
      check("hold_ready_low",  32'(ready_low), 32'd9);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("hold_hs%0d", i),   32'(i < hs.size() ? hs[i] : -1), 32'(4*i));
         check($sformatf("hold_resp%0d", i), 32'(i < rv.size() ? rv[i] : -1), 32'(4*i + 3));
         check($sformatf("hold_rdata%0d", i), i < rd.size() ? rd[i] : 32'hx,
               ref_load(hold_addr[i]));
      end

      // Reset during WAIT drops a pending store.
      @(negedge clk);
      b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 32'h40;
      b2.req_wdata = 32'h12345678; b2.req_be = 4'hF;
      check("abort_accept", 32'(b2.req_ready), 32'd1);
      @(negedge clk);
      b2.req_valid = 1'b0;
      check("abort_in_wait", 32'(b2.req_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", 32'(b2.req_ready), 32'd1);
      resp_seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (b2.resp_valid) resp_seen++;
         @(negedge clk);
      end
      check("abort_no_resp", 32'(resp_seen), 32'd0);
      run_op("abort_load", 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0);

      // Zero-latency build: response the cycle after handshake, next accept one later.
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'h8;
      b0.req_wdata = 32'h600DCAFE; b0.req_be = 4'hF;
      check("l0_accept", 32'(b0.req_ready), 32'd1);
      @(negedge clk);
      check("l0_resp",  {b0.resp_valid, b0.resp_err, b0.req_ready, 29'd0}, {3'b100, 29'd0});
      check("l0_srdata", b0.resp_rdata, 32'd0);
      b0.req_we = 1'b0;
      @(negedge clk);
      check("l0_reaccept", {b0.resp_valid, b0.req_ready, 30'd0}, {2'b01, 30'd0});
      @(negedge clk);
      b0.req_valid = 1'b0;
      check("l0_load_resp", 32'(b0.resp_valid), 32'd1);
      check("l0_load_rdata", b0.resp_rdata, 32'h600DCAFE);

      // Random traffic against the reference model.
      for (int w = 0; w < 16; w++)
         run_op($sformatf("init%0d", w), 1'b1, 32'(w*4), $urandom, 4'hF, 1'b0, 32'h0);
      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 9);
         ra  = 32'($urandom_range(0, 15)) << 2;
         if (sel == 0) ra = ra | 32'($urandom_range(1, 3));
         if (sel == 1) ra = 32'(DEPTH*4) + (32'($urandom_range(0, 255)) << 2);
         rwe = 1'($urandom_range(0, 1));
         rw  = $urandom;
         rb  = 4'($urandom_range(0, 15));
         run_op($sformatf("rnd%0d", t), rwe, ra, rw, rb, ref_err(rwe, ra, rb),
                (rwe || ref_err(rwe, ra, rb)) ? 32'h0 : ref_load(ra));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
